// File: rtl/fas_pkg.sv
// ---------------------------------------------------------------
// fas_pkg - shared types and constants for the FAS analyzer back end
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package fas_pkg;

  localparam int FAS_NPT = 16;
  localparam int FAS_DW  = 16;
  localparam int FAS_MW  = 2 * FAS_DW;

  // Field order puts re in the upper half, matching the fft_d bus layout.
  typedef struct packed {
    logic signed [FAS_DW-1:0] re;
    logic signed [FAS_DW-1:0] im;
  } fas_cplx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fas_ana_state_t;

endpackage

`default_nettype wire

// File: rtl/fas_mag2.sv
// ---------------------------------------------------------------
// fas_mag2 - combinational squared magnitude re*re + im*im
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module fas_mag2 #(
  parameter int DW = 16,
  parameter int MW = 2 * DW
) (
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic        [MW-1:0] mag
);

  logic signed [MW-1:0] re_ext;
  logic signed [MW-1:0] im_ext;
  logic signed [MW-1:0] re_sq;
  logic signed [MW-1:0] im_sq;

  assign re_ext = MW'(re);
  assign im_ext = MW'(im);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  // Each square is at most 2^30, so the unsigned sum peaks at 2^31 and fits.
  assign mag = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

`default_nettype wire

// File: rtl/fas_freq_analyzer.sv
// ---------------------------------------------------------------
// fas_freq_analyzer - reports the peak-magnitude bin of each FFT frame
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module fas_freq_analyzer
  import fas_pkg::*;
#(
  parameter int NPT = FAS_NPT,
  parameter int DW  = FAS_DW,
  parameter int MW  = 2 * DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fft_valid,
  input  logic [2*DW-1:0]         fft_d0,
  input  logic [2*DW-1:0]         fft_d1,
  input  logic [2*DW-1:0]         fft_d2,
  input  logic [2*DW-1:0]         fft_d3,
  input  logic [2*DW-1:0]         fft_d4,
  input  logic [2*DW-1:0]         fft_d5,
  input  logic [2*DW-1:0]         fft_d6,
  input  logic [2*DW-1:0]         fft_d7,
  input  logic [2*DW-1:0]         fft_d8,
  input  logic [2*DW-1:0]         fft_d9,
  input  logic [2*DW-1:0]         fft_d10,
  input  logic [2*DW-1:0]         fft_d11,
  input  logic [2*DW-1:0]         fft_d12,
  input  logic [2*DW-1:0]         fft_d13,
  input  logic [2*DW-1:0]         fft_d14,
  input  logic [2*DW-1:0]         fft_d15,
  output logic                    done,
  output logic [$clog2(NPT)-1:0]  freq,
  output logic                    overrun
);

  localparam int CW = $clog2(NPT);

  fas_cplx_t      frame_in [NPT];
  fas_cplx_t      hold     [NPT];
  fas_cplx_t      work     [NPT];
  fas_cplx_t      cur;
  fas_ana_state_t state;
  fas_ana_state_t state_nxt;
  logic           pending;
  logic           load;
  logic           done_nxt;
  logic           upd;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  max_idx;
  logic [CW-1:0]  final_idx;
  logic [MW-1:0]  max_mag;
  logic [MW-1:0]  mag;

  assign frame_in[0]  = fft_d0;
  assign frame_in[1]  = fft_d1;
  assign frame_in[2]  = fft_d2;
  assign frame_in[3]  = fft_d3;
  assign frame_in[4]  = fft_d4;
  assign frame_in[5]  = fft_d5;
  assign frame_in[6]  = fft_d6;
  assign frame_in[7]  = fft_d7;
  assign frame_in[8]  = fft_d8;
  assign frame_in[9]  = fft_d9;
  assign frame_in[10] = fft_d10;
  assign frame_in[11] = fft_d11;
  assign frame_in[12] = fft_d12;
  assign frame_in[13] = fft_d13;
  assign frame_in[14] = fft_d14;
  assign frame_in[15] = fft_d15;

  assign cur = work[cnt];

  fas_mag2 #(
    .DW (DW),
    .MW (MW)
  ) u_mag2 (
    .re  (cur.re),
    .im  (cur.im),
    .mag (mag)
  );

  // Strictly greater keeps the lowest index on ties.
  assign upd       = (mag > max_mag);
  assign final_idx = upd ? cnt : max_idx;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(NPT - 1)) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (pending) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      freq    <= '0;
      overrun <= 1'b0;
      pending <= 1'b0;
      cnt     <= '0;
      max_mag <= '0;
      max_idx <= '0;
    end else begin
      state   <= state_nxt;
      done    <= done_nxt;
      pending <= fft_valid | (pending & ~load);
      if (fft_valid && pending && !load) begin
        overrun <= 1'b1;
      end
      if (load) begin
        cnt     <= '0;
        max_mag <= '0;
        max_idx <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        if (upd) begin
          max_mag <= mag;
          max_idx <= cnt;
        end
      end
      // Registered here so freq and done appear together in the DONE cycle.
      if (done_nxt) begin
        freq <= final_idx;
      end
    end
  end

  // Frame data carries no control meaning, so it needs no reset.
  always_ff @(posedge clk) begin
    if (fft_valid) begin
      hold <= frame_in;
    end
    if (load) begin
      work <= hold;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fas_freq_analyzer.sv
// ---------------------------------------------------------------
// tb_fas_freq_analyzer - directed self-checking bench for fas_freq_analyzer
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_fas_freq_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] d [16];
  logic        done;
  logic [3:0]  freq;
  logic        overrun;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  fas_freq_analyzer dut (
    .clk       (clk),
    .rst       (rst),
    .fft_valid (fft_valid),
    .fft_d0    (d[0]),
    .fft_d1    (d[1]),
    .fft_d2    (d[2]),
    .fft_d3    (d[3]),
    .fft_d4    (d[4]),
    .fft_d5    (d[5]),
    .fft_d6    (d[6]),
    .fft_d7    (d[7]),
    .fft_d8    (d[8]),
    .fft_d9    (d[9]),
    .fft_d10   (d[10]),
    .fft_d11   (d[11]),
    .fft_d12   (d[12]),
    .fft_d13   (d[13]),
    .fft_d14   (d[14]),
    .fft_d15   (d[15]),
    .done      (done),
    .freq      (freq),
    .overrun   (overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame;
    for (int i = 0; i < 16; i++) d[i] = 32'h0;
  endtask

  // Peak of magnitude 1.0 at bin, smaller neighbour to exercise the compare.
  task automatic load_peak(input int bin);
    clear_frame();
    d[bin]          = 32'h0100_0000;
    d[(bin + 1) % 16] = 32'h0040_0040;
  endtask

  task automatic send;
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
  endtask

  // Counts cycles until done, capped so a missing pulse cannot hang the run.
  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < maxc) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    clear_frame();
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst_done", done, 0);
    chk("rst_freq", freq, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b1;
    tick();

    // Single frame, peak at bin 5: done 18 cycles after the strobe.
    clear_frame();
    d[5] = 32'h0100_0000;
    send();
    wait_done(40, n);
    chk("single_lat", n, 17);
    chk("single_freq", freq, 5);
    chk("single_ovr", overrun, 0);
    tick();
    chk("single_pulse", done, 0);
    chk("single_hold", freq, 5);

    // Tie between bins 3 and 9 keeps the lower index.
    clear_frame();
    d[3] = 32'h0080_0080;
    d[9] = 32'h0080_0080;
    send();
    wait_done(40, n);
    chk("tie_lat", n, 17);
    chk("tie_freq", freq, 3);
    tick();

    // Extreme values: 2^31 beats 2*0x3FFF0001.
    clear_frame();
    d[2]  = 32'h7FFF_7FFF;
    d[12] = 32'h8000_8000;
    send();
    wait_done(40, n);
    chk("ext_lat", n, 17);
    chk("ext_freq", freq, 12);
    tick();

    // All-zero frame reports bin 0 and freq holds afterwards.
    clear_frame();
    send();
    wait_done(40, n);
    chk("zero_lat", n, 17);
    chk("zero_freq", freq, 0);
    repeat (5) tick();
    chk("zero_hold_freq", freq, 0);
    chk("zero_hold_done", done, 0);

    // Back-to-back frames every 16 cycles: done at 18, 35, 52.
    for (int k = 0; k <= 60; k++) begin
      if (k == 0 || k == 16 || k == 32) begin
        load_peak(k == 0 ? 1 : (k == 16 ? 14 : 7));
        fft_valid = 1'b1;
      end else begin
        fft_valid = 1'b0;
      end
      chk("b2b_done", done, (k == 18 || k == 35 || k == 52) ? 1 : 0);
      if (k == 18) chk("b2b_freq0", freq, 1);
      if (k == 35) chk("b2b_freq1", freq, 14);
      if (k == 52) chk("b2b_freq2", freq, 7);
      tick();
    end
    fft_valid = 1'b0;
    chk("b2b_ovr", overrun, 0);

    // Three strobes in a row: middle frame is lost, overrun from cycle 3.
    for (int k = 0; k <= 40; k++) begin
      if (k <= 2) begin
        load_peak(k == 0 ? 4 : (k == 1 ? 8 : 11));
        fft_valid = 1'b1;
      end else begin
        fft_valid = 1'b0;
      end
      chk("ovr_done", done, (k == 18 || k == 35) ? 1 : 0);
      chk("ovr_flag", overrun, (k >= 3) ? 1 : 0);
      if (k == 18) chk("ovr_freq0", freq, 4);
      if (k == 35) chk("ovr_freq1", freq, 11);
      tick();
    end
    fft_valid = 1'b0;

    // Reset while RUN is at cnt=8, held for two cycles.
    load_peak(13);
    send();
    repeat (9) tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_freq", freq, 0);
    chk("mid_rst_ovr", overrun, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      chk("post_rst_nodone", done, 0);
      tick();
    end
    chk("post_rst_ovr", overrun, 0);

    load_peak(6);
    send();
    wait_done(40, n);
    chk("post_rst_lat", n, 17);
    chk("post_rst_freq", freq, 6);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
